byte_mem_ctrl: RTL
==================

// Module: byte_mem_ctrl
// PURPOSE
//  Parametrised byte-addressed RAM with strobed writes, a pipelined read path,
//  configurable address wrap, a read/write collision policy and a hardware
//  clear sweep. Second-generation memory behind the AXI slave. Write-complete
//  is signalled by writefinish, read data by rvalid.
// PARAMETERS
//  DATA_W    32  word width in bits; multiple of 8; NB = DATA_W/8 bytes
//  ADDR_W    7   byte-address width
//  DEPTH     128 bytes of storage; <= 2**ADDR_W; multiple of NB
//  RD_LAT    1   read latency in cycles; only 1 or 2 are legal
//  WRAP      1   1: byte address wraps modulo DEPTH; 0: out-of-range bytes are errors
//  WR_FIRST  0   same-cycle overlap: 1 returns new bytes, 0 returns old bytes
// PORTS
//  CLK          in   1       clock; all logic on posedge
//  RST          in   1       asynchronous reset, active-high
//  CS           in   1       chip select; gates WE and RE
//  WE           in   1       write request
//  WADDR        in   ADDR_W  write byte address; no alignment required
//  WSTRB        in   NB      byte enables; bit k maps to Mem_in[8k+7:8k]
//  Mem_in       in   DATA_W  write data, little-endian
//  RE           in   1       read request
//  RADDR        in   ADDR_W  read byte address
//  CLR          in   1       start clear sweep (one-cycle pulse)
//  Mem_out      out  DATA_W  read data; holds its last value while rvalid=0
//  rvalid       out  1       one-cycle pulse marking Mem_out valid
//  writefinish  out  1       one-cycle pulse marking write complete
//  addr_err     out  1       pulse alongside rvalid/writefinish of an out-of-range access
//  busy         out  1       clear sweep in progress
// BEHAVIOUR
//  - RST=1 (async): Mem_out=0, rvalid=0, writefinish=0, addr_err=0, busy=0,
//    FSM=IDLE, sweep ptr=0, read pipe flushed. RAM contents are NOT reset.
//  - Write accepted when CS&WE&!busy. For each k with WSTRB[k]=1,
//    RAM[WADDR+k] <= Mem_in[8k+7:8k]. writefinish=1 in the following cycle only.
//    Back-to-back writes hold writefinish high. WSTRB=0 still pulses writefinish.
//  - Read accepted when CS&RE&!busy.
//    Mem_out={RAM[RADDR+NB-1],...,RAM[RADDR]}; rvalid rises RD_LAT cycles after
//    acceptance. One read per cycle, fully pipelined.
//  - Address wrap:
//    - WRAP=1: every byte address is taken modulo DEPTH.
//    - WRAP=0: bytes at address >= DEPTH are dropped on write and read as 0x00.
//      addr_err pulses with that access's writefinish or rvalid.
//  - Collision (read and write accepted in the same cycle, overlapping bytes):
//    - WR_FIRST=1: each strobed byte returns the new value.
//    - WR_FIRST=0: all bytes return the old value.
//  - FSM IDLE/CLEAR:
//    - IDLE & CLR: go to CLEAR, busy=1 next cycle, ptr=0.
//    - CLEAR: zero bytes ptr..ptr+NB-1 each cycle, ptr+=NB.
//    - Last group written: return to IDLE, busy=0 next cycle.
//    - The sweep lasts DEPTH/NB cycles.
//  - While busy: WE, RE and CLR are ignored; no writefinish or rvalid is produced
//    for them. Reads accepted before CLR still complete.
//  - CLR with a same-cycle access: the access is accepted, then the sweep starts.
//  - RST mid-sweep: FSM returns to IDLE; memory stays partially cleared.
// STRUCTURE
//  - Package mem_pkg: state enum {ST_IDLE, ST_CLEAR}; localparam NB; function
//    in_range(addr,k) used by the WRAP=0 checks.
//  - Sub-module mem_rd_pipe: RD_LAT-deep delay line carrying {data, valid, err};
//    async reset clears the valid and err bits.
//  - RAM array, write/collision logic and the FSM stay in this module.
// TESTING (DATA_W=32, DEPTH=128, RD_LAT=1 unless stated)
//  1. Write 0xDEADBEEF @0x10, WSTRB=4'hF -> writefinish 1 cycle later;
//     read @0x10 -> Mem_out=0xDEADBEEF, rvalid 1 cycle later (RD_LAT=2: 2 cycles).
//  2. Over test 1, write 0x11223344 @0x10, WSTRB=4'b0101
//     -> read @0x10 returns 0xDE22BE44.
//  3. Write 0xA1B2C3D4 @126:
//     - WRAP=1 -> RAM[126]=D4, [127]=C3, [0]=B2, [1]=A1.
//     - WRAP=0 -> RAM[0..1] unchanged, addr_err pulses, read @126 returns 0x0000C3D4.
//  4. RAM@0x20=0; same-cycle write 0x55555555 and read @0x20
//     -> WR_FIRST=0 returns 0x0, WR_FIRST=1 returns 0x55555555.
//  5. CLR pulse -> busy high exactly 32 cycles; a write during busy gives no
//     writefinish; afterwards reads @0,0x40,0x7C all return 0.
//  6. RST asserted at sweep cycle 10 with a read in flight -> busy, rvalid and
//     writefinish go 0 asynchronously; after release, FSM is IDLE and new
//     accesses are accepted.

Source files
------------

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and helpers for byte_mem_ctrl: controller state
//               encoding, default bytes-per-word and the address range check
//               used when the address does not wrap.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Bytes per word at the default 32-bit data width.
  localparam int NB = 4;

  // True when byte k of an access starting at addr lies inside the array.
  function automatic logic in_range(input int addr, input int k, input int depth);
    return (addr + k) < depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mem_rd_pipe
// Description : RD_LAT-deep delay line carrying read data, valid and error.
//               A stage only reloads its data when valid data arrives, so the
//               output holds the last delivered word between reads.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_valid/i_err - read accepted this cycle / it was out of range
//               i_data        - word read this cycle
//               o_valid/o_err/o_data - delayed copies
// Revision    : 1.0 - initial release
// ============================================================================
module mem_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_err,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic              o_err,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] r_data [RD_LAT];
  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      r_err <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        r_data[s] <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      r_err[0] <= i_err;
      if (i_valid) begin
        r_data[0] <= i_data;
      end
      for (int s = 1; s < RD_LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_err[s] <= r_err[s-1];
        if (r_vld[s-1]) begin
          r_data[s] <= r_data[s-1];
        end
      end
    end
  end

  assign o_valid = r_vld[RD_LAT-1];
  assign o_err   = r_err[RD_LAT-1];
  assign o_data  = r_data[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/byte_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : byte_mem_ctrl
// Description : Byte-addressed RAM with strobed unaligned writes, pipelined
//               word reads, optional address wrap, selectable read/write
//               collision policy and a hardware clear sweep.
// Ports       : CLK, RST      - clock, asynchronous active-high reset
//               CS, WE, RE    - chip select, write / read request
//               WADDR, WSTRB, Mem_in - write byte address, byte enables, data
//               RADDR         - read byte address
//               CLR           - start clear sweep
//               Mem_out, rvalid - read data and its valid pulse
//               writefinish   - write complete pulse
//               addr_err      - out-of-range access (WRAP=0 only)
//               busy          - clear sweep running
// Revision    : 1.0 - initial release
// ============================================================================
module byte_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W   = 8 * NB,
  parameter int ADDR_W   = 7,
  parameter int DEPTH    = 128,
  parameter int RD_LAT   = 1,
  parameter bit WRAP     = 1'b1,
  parameter bit WR_FIRST = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                CS,
  input  logic                WE,
  input  logic [ADDR_W-1:0]   WADDR,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic [DATA_W-1:0]   Mem_in,
  input  logic                RE,
  input  logic [ADDR_W-1:0]   RADDR,
  input  logic                CLR,
  output logic [DATA_W-1:0]   Mem_out,
  output logic                rvalid,
  output logic                writefinish,
  output logic                addr_err,
  output logic                busy
);

  localparam int c_nb = DATA_W / 8;
  localparam int c_iw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - c_nb);

  logic [7:0]        r_mem [DEPTH];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_wf;
  logic              r_wr_err;

  logic              w_busy;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_wr_bad;
  logic              w_rd_bad;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_pipe_err;

  // Physical byte index of byte k of an access at address a. With WRAP=0 the
  // caller only uses it for in-range bytes, where the modulo is an identity.
  function automatic logic [c_iw-1:0] f_idx(input logic [ADDR_W-1:0] a, input int k);
    return c_iw'((int'(a) + k) % DEPTH);
  endfunction

  function automatic logic f_ok(input logic [ADDR_W-1:0] a, input int k);
    return WRAP || in_range(int'(a), k, DEPTH);
  endfunction

  assign w_busy   = (r_state == ST_CLEAR);
  assign w_wr_acc = CS && WE && !w_busy;
  assign w_rd_acc = CS && RE && !w_busy;

  // Read word assembly, range errors and collision forwarding. Reading the
  // array before the edge naturally yields old data; WR_FIRST substitutes the
  // bytes being written in the same cycle.
  always_comb begin
    w_wr_bad  = 1'b0;
    w_rd_bad  = 1'b0;
    w_rd_data = '0;
    for (int k = 0; k < c_nb; k++) begin
      if (WSTRB[k] && !f_ok(WADDR, k)) begin
        w_wr_bad = 1'b1;
      end
      if (!f_ok(RADDR, k)) begin
        w_rd_bad = 1'b1;
      end else begin
        w_rd_data[8*k +: 8] = r_mem[f_idx(RADDR, k)];
        if (WR_FIRST && w_wr_acc) begin
          for (int j = 0; j < c_nb; j++) begin
            if (WSTRB[j] && f_ok(WADDR, j) && (f_idx(WADDR, j) == f_idx(RADDR, k))) begin
              w_rd_data[8*k +: 8] = Mem_in[8*j +: 8];
            end
          end
        end
      end
    end
  end

  // Clear sweep controller.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (CLR) begin
          w_state_nxt = ST_CLEAR;
          w_ptr_nxt   = '0;
        end
      end
      ST_CLEAR: begin
        if (r_ptr == c_last) begin
          w_state_nxt = ST_IDLE;
          w_ptr_nxt   = '0;
        end else begin
          w_ptr_nxt = r_ptr + ADDR_W'(c_nb);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_wf     <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ptr    <= w_ptr_nxt;
      r_wf     <= w_wr_acc;
      r_wr_err <= w_wr_acc && w_wr_bad;
    end
  end

  // Storage has no reset; a reset mid-sweep leaves it partially cleared.
  always_ff @(posedge CLK) begin
    if (w_busy) begin
      for (int k = 0; k < c_nb; k++) begin
        r_mem[c_iw'(int'(r_ptr) + k)] <= 8'h00;
      end
    end else if (w_wr_acc) begin
      for (int k = 0; k < c_nb; k++) begin
        if (WSTRB[k] && f_ok(WADDR, k)) begin
          r_mem[f_idx(WADDR, k)] <= Mem_in[8*k +: 8];
        end
      end
    end
  end

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (CLK),
    .rst     (RST),
    .i_valid (w_rd_acc),
    .i_err   (w_rd_acc && w_rd_bad),
    .i_data  (w_rd_data),
    .o_valid (rvalid),
    .o_err   (w_pipe_err),
    .o_data  (Mem_out)
  );

  assign writefinish = r_wf;
  assign addr_err    = r_wr_err || w_pipe_err;
  assign busy        = w_busy;

endmodule
`default_nettype wire
